// File: rtl/ttt_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ttt_pkg
//  Purpose  : Shared types and constants for the tic-tac-toe game-state stage:
//             FSM state encoding, winner codes and the eight winning-line masks.
//  Config   : TTT_SCORE_EN (used by ttt_board_ctrl) enables score counters.
//  Revision : 1.0 - initial release
// ============================================================================
package ttt_pkg;

  localparam int NUM_SQUARES = 9;

  typedef enum logic [1:0] {
    PLAY  = 2'd0,
    CHECK = 2'd1,
    WIN   = 2'd2,
    DRAW  = 2'd3
  } state_t;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_X    = 2'b01;
  localparam logic [1:0] WIN_O    = 2'b10;
  localparam logic [1:0] WIN_DRAW = 2'b11;

  // Square bit 0 is top-left, row-major. Index order: rows 0-2, cols 3-5,
  // main diagonal 6, anti-diagonal 7.
  localparam logic [NUM_SQUARES-1:0] WIN_LINES [0:7] = '{
    9'h007, 9'h038, 9'h1C0,
    9'h049, 9'h092, 9'h124,
    9'h111, 9'h054
  };

endpackage
`default_nettype wire

// File: rtl/ttt_win_detect.sv
`default_nettype none
// ============================================================================
//  Module   : ttt_win_detect
//  Purpose  : Combinational line checker. Flags every winning line fully
//             covered by one player's board.
//  Revision : 1.0 - initial release
// ============================================================================
module ttt_win_detect
  import ttt_pkg::*;
(
  input  logic [NUM_SQUARES-1:0] board,
  output logic [7:0]             line_hit
);

  // One comparator per line: a line is hit when all three of its squares are owned
  for (genvar i = 0; i < 8; i++) begin : g_line
    assign line_hit[i] = ((board & WIN_LINES[i]) == WIN_LINES[i]);
  end

endmodule
`default_nettype wire

// File: rtl/ttt_board_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : ttt_board_ctrl
//  Purpose  : Tic-tac-toe game state. Converts the held one-hot square vector
//             into single move events, keeps the X/O board, alternates turns
//             and reports win/draw status.
//  Config   : define TTT_SCORE_EN to build saturating per-player win counters;
//             otherwise score_x/score_o are tied to zero.
//  Revision : 1.0 - initial release
// ============================================================================
module ttt_board_ctrl
  import ttt_pkg::*;
#(
  parameter bit FIRST_PLAYER = 1'b0,
  parameter int SCORE_W      = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [NUM_SQUARES-1:0] clicked_matrix,
  input  logic                   new_game,
  output logic [NUM_SQUARES-1:0] board_x,
  output logic [NUM_SQUARES-1:0] board_o,
  output logic                   turn,
  output logic                   game_over,
  output logic [1:0]             winner,
  output logic [7:0]             win_line,
  output logic                   move_ok,
  output logic                   move_rej,
  output logic [SCORE_W-1:0]     score_x,
  output logic [SCORE_W-1:0]     score_o
);

  state_t                 r_state, w_state_nxt;
  logic [NUM_SQUARES-1:0] r_board_x, r_board_o, w_board_x_nxt, w_board_o_nxt;
  logic                   r_turn, w_turn_nxt;
  logic [1:0]             r_winner, w_winner_nxt;
  logic [7:0]             r_win_line, w_win_line_nxt;
  logic                   r_game_over, w_game_over_nxt;
  logic                   r_move_ok, w_move_ok_nxt;
  logic                   r_move_rej, w_move_rej_nxt;
  logic                   r_prev_any;

  logic                   w_any, w_evt;
  logic [NUM_SQUARES-1:0] w_sel, w_occ, w_mover_board;
  logic [7:0]             w_hit;

  // Rising edge of "any square pressed" gives one event per press; the
  // lowest set bit wins if the decoder ever reports more than one square.
  assign w_any         = |clicked_matrix;
  assign w_evt         = w_any & ~r_prev_any;
  assign w_sel         = clicked_matrix & (~clicked_matrix + 9'd1);
  assign w_occ         = r_board_x | r_board_o;
  // In CHECK the board already holds the new move and turn still names the mover
  assign w_mover_board = r_turn ? r_board_o : r_board_x;

  ttt_win_detect u_win_detect (
    .board    (w_mover_board),
    .line_hit (w_hit)
  );

  // State and game registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= PLAY;
      r_board_x   <= '0;
      r_board_o   <= '0;
      r_turn      <= FIRST_PLAYER;
      r_winner    <= WIN_NONE;
      r_win_line  <= '0;
      r_game_over <= 1'b0;
      r_move_ok   <= 1'b0;
      r_move_rej  <= 1'b0;
      r_prev_any  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_board_x   <= w_board_x_nxt;
      r_board_o   <= w_board_o_nxt;
      r_turn      <= w_turn_nxt;
      r_winner    <= w_winner_nxt;
      r_win_line  <= w_win_line_nxt;
      r_game_over <= w_game_over_nxt;
      r_move_ok   <= w_move_ok_nxt;
      r_move_rej  <= w_move_rej_nxt;
      r_prev_any  <= w_any;
    end
  end

  // Next-state and next-board logic; new_game overrides any same-cycle click
  always_comb begin
    w_state_nxt     = r_state;
    w_board_x_nxt   = r_board_x;
    w_board_o_nxt   = r_board_o;
    w_turn_nxt      = r_turn;
    w_winner_nxt    = r_winner;
    w_win_line_nxt  = r_win_line;
    w_game_over_nxt = r_game_over;
    w_move_ok_nxt   = 1'b0;
    w_move_rej_nxt  = 1'b0;
    if (new_game) begin
      w_state_nxt     = PLAY;
      w_board_x_nxt   = '0;
      w_board_o_nxt   = '0;
      w_turn_nxt      = FIRST_PLAYER;
      w_winner_nxt    = WIN_NONE;
      w_win_line_nxt  = '0;
      w_game_over_nxt = 1'b0;
    end else begin
      case (r_state)
        PLAY: begin
          if (w_evt) begin
            if ((w_sel & w_occ) != '0) begin
              w_move_rej_nxt = 1'b1;
            end else begin
              if (r_turn) w_board_o_nxt = r_board_o | w_sel;
              else        w_board_x_nxt = r_board_x | w_sel;
              w_move_ok_nxt = 1'b1;
              w_state_nxt   = CHECK;
            end
          end
        end
        CHECK: begin
          w_move_rej_nxt = w_evt;
          if (|w_hit) begin
            w_state_nxt     = WIN;
            w_winner_nxt    = r_turn ? WIN_O : WIN_X;
            w_win_line_nxt  = w_hit;
            w_game_over_nxt = 1'b1;
          end else if (&w_occ) begin
            w_state_nxt     = DRAW;
            w_winner_nxt    = WIN_DRAW;
            w_game_over_nxt = 1'b1;
          end else begin
            w_state_nxt = PLAY;
            w_turn_nxt  = ~r_turn;
          end
        end
        default: begin
          w_move_rej_nxt = w_evt;
        end
      endcase
    end
  end

  assign board_x   = r_board_x;
  assign board_o   = r_board_o;
  assign turn      = r_turn;
  assign game_over = r_game_over;
  assign winner    = r_winner;
  assign win_line  = r_win_line;
  assign move_ok   = r_move_ok;
  assign move_rej  = r_move_rej;

`ifdef TTT_SCORE_EN
  logic [SCORE_W-1:0] r_score_x, r_score_o;
  logic               w_win_evt;

  assign w_win_evt = (r_state == CHECK) && !new_game && (|w_hit);

  // Credit each won game to its winner, holding at the maximum count
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_score_x <= '0;
      r_score_o <= '0;
    end else if (w_win_evt) begin
      if (r_turn) begin
        if (r_score_o != '1) r_score_o <= r_score_o + SCORE_W'(1);
      end else begin
        if (r_score_x != '1) r_score_x <= r_score_x + SCORE_W'(1);
      end
    end
  end

  assign score_x = r_score_x;
  assign score_o = r_score_o;
`else
  assign score_x = '0;
  assign score_o = '0;
`endif

endmodule
`default_nettype wire
